// File: rtl/rc4_prga_decryptor.sv
// rc4_prga_decryptor
// Runs the RC4 pseudo-random generation loop over an externally held,
// already key-scheduled S-box. It XORs the keystream with a 32-byte
// encrypted message and produces the plaintext.
//
// Ports
//   clk            single clock, rising edge
//   reset          synchronous, active-high
//   start          level, sampled only while idle; begins one 32-byte run
//   s_address      S-box RAM address (registered)
//   s_data         S-box RAM write data (registered)
//   s_wren         S-box RAM write enable (registered)
//   s_q            S-box RAM read data, valid two cycles after the address is set
//   rom_address    encrypted-message ROM address (byte index k)
//   rom_q          encrypted byte, same read timing as s_q
//   decrypted_data plaintext bytes, entry k written when byte k completes
//   done           high while the run has finished (sticky until reset)
//   text_valid     high while every byte so far is a lowercase letter or a space
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// INC_I   | i <= i+1, request S[i+1]
// WAIT_SI | S-RAM read latency
// READ_SI | capture si, j <= j+si, request S[j]
// WAIT_SJ | S-RAM read latency
// READ_SJ | capture sj
// WR_SI   | write S[i] <= sj
// WR_SJ   | write S[j] <= si
// ADDR_F  | stop writing, request S[si+sj] and ROM[k]
// WAIT_F  | read latency plus one slack cycle (11-cycle byte cadence)
// READ_F  | store plaintext byte k, advance k or finish
// DONE    | run complete; hold everything until reset

module rc4_prga_decryptor (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic [7:0] s_address,
   output logic [7:0] s_data,
   output logic       s_wren,
   input  logic [7:0] s_q,
   output logic [4:0] rom_address,
   input  logic [7:0] rom_q,
   output logic [7:0] decrypted_data [31:0],
   output logic       done,
   output logic       text_valid
);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      INC_I   = 4'd1,
      WAIT_SI = 4'd2,
      READ_SI = 4'd3,
      WAIT_SJ = 4'd4,
      READ_SJ = 4'd5,
      WR_SI   = 4'd6,
      WR_SJ   = 4'd7,
      ADDR_F  = 4'd8,
      WAIT_F  = 4'd9,
      READ_F  = 4'd10,
      DONE    = 4'd11
   } state_t;

   state_t     state;
   state_t     state_nx;
   logic [7:0] i;
   logic [7:0] j;
   logic [7:0] si;
   logic [7:0] sj;
   logic [4:0] k;
   logic       wait_cnt;
   logic [7:0] plain;
   logic       plain_ok;

   assign plain    = s_q ^ rom_q;
   assign plain_ok = ((plain >= 8'h61) && (plain <= 8'h7A)) || (plain == 8'h20);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = INC_I;
         INC_I:   state_nx = WAIT_SI;
         WAIT_SI: state_nx = READ_SI;
         READ_SI: state_nx = WAIT_SJ;
         WAIT_SJ: state_nx = READ_SJ;
         READ_SJ: state_nx = WR_SI;
         WR_SI:   state_nx = WR_SJ;
         WR_SJ:   state_nx = ADDR_F;
         ADDR_F:  state_nx = WAIT_F;
         WAIT_F:  if (wait_cnt == 1'b0) state_nx = READ_F;
         READ_F:  state_nx = (k == 5'd31) ? DONE : INC_I;
         DONE:    state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      done = (state == DONE);
   end

   // Datapath and registered RAM/ROM controls.
   always_ff @(posedge clk) begin
      if (reset) begin
         i           <= 8'd0;
         j           <= 8'd0;
         si          <= 8'd0;
         sj          <= 8'd0;
         k           <= 5'd0;
         wait_cnt    <= 1'b0;
         s_address   <= 8'd0;
         s_data      <= 8'd0;
         s_wren      <= 1'b0;
         rom_address <= 5'd0;
         text_valid  <= 1'b1;
         for (int n = 0; n < 32; n++) decrypted_data[n] <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  i <= 8'd0;
                  j <= 8'd0;
                  k <= 5'd0;
               end
            end
            INC_I: begin
               i         <= i + 8'd1;
               s_address <= i + 8'd1;
            end
            READ_SI: begin
               si        <= s_q;
               j         <= j + s_q;
               s_address <= j + s_q;
            end
            READ_SJ: sj <= s_q;
            WR_SI: begin
               s_address <= i;
               s_data    <= sj;
               s_wren    <= 1'b1;
            end
            WR_SJ: begin
               s_address <= j;
               s_data    <= si;
               s_wren    <= 1'b1;
            end
            ADDR_F: begin
               s_wren      <= 1'b0;
               s_address   <= si + sj;
               rom_address <= k;
               wait_cnt    <= 1'b1;
            end
            WAIT_F: wait_cnt <= wait_cnt - 1'b1;
            READ_F: begin
               decrypted_data[k] <= plain;
               if (!plain_ok) text_valid <= 1'b0;
               if (k != 5'd31) k <= k + 5'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rc4_prga_decryptor.sv
// Self-checking bench for rc4_prga_decryptor: models the S-box RAM and
// message ROM (one-cycle synchronous read of the registered address) and
// checks against a plain software RC4 PRGA reference.
module tb_rc4_prga_decryptor;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] s_address;
   logic [7:0] s_data;
   logic       s_wren;
   logic [7:0] s_q;
   logic [4:0] rom_address;
   logic [7:0] rom_q;
   logic [7:0] decrypted_data [31:0];
   logic       done;
   logic       text_valid;

   logic [7:0] smem [256];
   logic [7:0] rom  [32];
   logic [7:0] exp_pt [32];
   logic       exp_tv;
   int         wr_count = 0;
   int         vectors = 0;
   int         miscompares = 0;

   rc4_prga_decryptor dut (
      .clk(clk), .reset(reset), .start(start),
      .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
      .rom_address(rom_address), .rom_q(rom_q),
      .decrypted_data(decrypted_data), .done(done), .text_valid(text_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (s_wren) begin
         smem[s_address] <= s_data;
         wr_count <= wr_count + 1;
      end
      s_q   <= smem[s_address];
      rom_q <= rom[rom_address];
   end

   // Software RC4 PRGA over the current smem/rom contents.
   task automatic ref_model();
      logic [7:0] ms [256];
      logic [7:0] ii, jj, t, f;
      for (int n = 0; n < 256; n++) ms[n] = smem[n];
      ii = 8'd0; jj = 8'd0; exp_tv = 1'b1;
      for (int n = 0; n < 32; n++) begin
         ii = ii + 8'd1;
         jj = jj + ms[ii];
         t = ms[ii]; ms[ii] = ms[jj]; ms[jj] = t;
         f = ms[ii] + ms[jj];
         exp_pt[n] = ms[f] ^ rom[n];
         if (!((exp_pt[n] >= 8'h61 && exp_pt[n] <= 8'h7A) || exp_pt[n] == 8'h20))
            exp_tv = 1'b0;
      end
   endtask

   task automatic load_identity();
      for (int n = 0; n < 256; n++) smem[n] = 8'(n);
   endtask

   task automatic load_ksa();
      logic [7:0] key [16];
      logic [7:0] jj, t;
      int len;
      len = $urandom_range(3, 16);
      for (int n = 0; n < 16; n++) key[n] = 8'($urandom);
      load_identity();
      jj = 8'd0;
      for (int n = 0; n < 256; n++) begin
         jj = jj + smem[n] + key[n % len];
         t = smem[n]; smem[n] = smem[jj]; smem[jj] = t;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Drives start into one edge, then waits (bounded) for done.
   task automatic run_dut(output int cyc, output bit timed_out);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 1000) begin
         @(posedge clk); #1;
         cyc++;
      end
      timed_out = !done;
   endtask

   task automatic test_reset();
      bit zero;
      reset = 1'b1; start = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      zero = 1'b1;
      for (int n = 0; n < 32; n++) if (decrypted_data[n] !== 8'd0) zero = 1'b0;
      vectors += 6;
      if (s_wren !== 1'b0)        begin miscompares++; $display("FAIL reset_wren got %b want 0", s_wren); end
      if (s_address !== 8'd0)     begin miscompares++; $display("FAIL reset_saddr got %h want 00", s_address); end
      if (rom_address !== 5'd0)   begin miscompares++; $display("FAIL reset_romaddr got %h want 00", rom_address); end
      if (done !== 1'b0)          begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
      if (text_valid !== 1'b1)    begin miscompares++; $display("FAIL reset_tv got %b want 1", text_valid); end
      if (!zero)                  begin miscompares++; $display("FAIL reset_data got nonzero want all 00"); end
      reset = 1'b0; start = 1'b0;
   endtask

   task automatic test_identity_zero();
      int cyc; bit to;
      do_reset();
      load_identity();
      for (int n = 0; n < 32; n++) rom[n] = 8'h00;
      ref_model();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      vectors += 2;
      if (text_valid !== 1'b1)        begin miscompares++; $display("FAIL id_tv_before got %b want 1", text_valid); end
      if (decrypted_data[0] !== 8'h00) begin miscompares++; $display("FAIL id_d0_before got %h want 00", decrypted_data[0]); end
      @(posedge clk); #1;
      vectors += 3;
      if (decrypted_data[0] !== 8'h02) begin miscompares++; $display("FAIL id_d0 got %h want 02", decrypted_data[0]); end
      if (text_valid !== 1'b0)        begin miscompares++; $display("FAIL id_tv_after0 got %b want 0", text_valid); end
      if (decrypted_data[1] !== 8'h00) begin miscompares++; $display("FAIL id_d1_unwritten got %h want 00", decrypted_data[1]); end
      repeat (11) begin @(posedge clk); #1; end
      vectors += 3;
      if (decrypted_data[1] !== 8'h05) begin miscompares++; $display("FAIL id_d1 got %h want 05", decrypted_data[1]); end
      if (smem[2] !== 8'h03)          begin miscompares++; $display("FAIL id_s2 got %h want 03", smem[2]); end
      if (smem[3] !== 8'h02)          begin miscompares++; $display("FAIL id_s3 got %h want 02", smem[3]); end
      cyc = 0;
      while (!done && cyc < 1000) begin @(posedge clk); #1; cyc++; end
      to = !done;
      vectors++;
      if (to) begin miscompares++; $display("FAIL id_timeout got done=0 want done=1"); end
      for (int n = 0; n < 32; n++) begin
         vectors++;
         if (decrypted_data[n] !== exp_pt[n])
            begin miscompares++; $display("FAIL id_byte%0d got %h want %h", n, decrypted_data[n], exp_pt[n]); end
      end
   endtask

   task automatic test_text_valid();
      int cyc; bit to;
      do_reset();
      load_identity();
      for (int n = 0; n < 32; n++) rom[n] = 8'h00;
      rom[0] = 8'h63; rom[1] = 8'h64;
      ref_model();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (22) begin @(posedge clk); #1; end
      vectors += 3;
      if (decrypted_data[0] !== 8'h61) begin miscompares++; $display("FAIL tv_d0 got %h want 61", decrypted_data[0]); end
      if (decrypted_data[1] !== 8'h61) begin miscompares++; $display("FAIL tv_d1 got %h want 61", decrypted_data[1]); end
      if (text_valid !== 1'b1)        begin miscompares++; $display("FAIL tv_after1 got %b want 1", text_valid); end
      cyc = 0;
      while (!done && cyc < 1000) begin @(posedge clk); #1; cyc++; end
      to = !done;
      vectors += 2;
      if (to) begin miscompares++; $display("FAIL tv_timeout got done=0 want done=1"); end
      if (text_valid !== exp_tv) begin miscompares++; $display("FAIL tv_final got %b want %b", text_valid, exp_tv); end
   endtask

   task automatic test_timing_sticky();
      int cyc, w0; bit to, stay, frozen, quiet;
      logic [7:0] snap [32];
      do_reset();
      load_ksa();
      for (int n = 0; n < 32; n++) rom[n] = 8'($urandom);
      w0 = wr_count;
      run_dut(cyc, to);
      vectors += 3;
      if (to)               begin miscompares++; $display("FAIL tim_timeout got done=0 want done=1"); end
      if (cyc != 352)       begin miscompares++; $display("FAIL tim_cycles got %0d want 352", cyc); end
      if (wr_count - w0 != 64) begin miscompares++; $display("FAIL tim_writes got %0d want 64", wr_count - w0); end
      for (int n = 0; n < 32; n++) snap[n] = decrypted_data[n];
      w0 = wr_count;
      stay = 1'b1; frozen = 1'b1; quiet = 1'b1;
      for (int c = 0; c < 100; c++) begin
         start = 1'($urandom);
         @(posedge clk); #1;
         if (done !== 1'b1) stay = 1'b0;
         if (s_wren !== 1'b0) quiet = 1'b0;
         for (int n = 0; n < 32; n++) if (decrypted_data[n] !== snap[n]) frozen = 1'b0;
      end
      start = 1'b0;
      vectors += 4;
      if (!stay)   begin miscompares++; $display("FAIL sticky_done got low want 1 for 100 cycles"); end
      if (!quiet)  begin miscompares++; $display("FAIL sticky_wren got 1 want 0"); end
      if (!frozen) begin miscompares++; $display("FAIL sticky_data got changed want frozen"); end
      if (wr_count != w0) begin miscompares++; $display("FAIL sticky_writes got %0d want 0", wr_count - w0); end
   endtask

   task automatic test_j_wrap();
      int cyc; bit to;
      do_reset();
      load_identity();
      smem[1] = 8'hFF; smem[255] = 8'h01;
      for (int n = 0; n < 32; n++) rom[n] = 8'($urandom);
      ref_model();
      run_dut(cyc, to);
      vectors++;
      if (to) begin miscompares++; $display("FAIL wrap_timeout got done=0 want done=1"); end
      for (int n = 0; n < 32; n++) begin
         vectors++;
         if (decrypted_data[n] !== exp_pt[n])
            begin miscompares++; $display("FAIL wrap_byte%0d got %h want %h", n, decrypted_data[n], exp_pt[n]); end
      end
      vectors++;
      if (text_valid !== exp_tv) begin miscompares++; $display("FAIL wrap_tv got %b want %b", text_valid, exp_tv); end
   endtask

   task automatic test_reset_midrun();
      int w0; bit ok10, zero;
      do_reset();
      load_ksa();
      for (int n = 0; n < 32; n++) rom[n] = 8'($urandom);
      ref_model();
      w0 = wr_count;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (115) begin @(posedge clk); #1; end
      ok10 = 1'b1;
      for (int n = 0; n < 10; n++) if (decrypted_data[n] !== exp_pt[n]) ok10 = 1'b0;
      vectors += 2;
      if (!ok10) begin miscompares++; $display("FAIL mid_first10 got mismatch want model bytes 0..9"); end
      if (wr_count - w0 != 20) begin miscompares++; $display("FAIL mid_writes_before got %0d want 20", wr_count - w0); end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      zero = 1'b1;
      for (int n = 0; n < 32; n++) if (decrypted_data[n] !== 8'd0) zero = 1'b0;
      vectors += 4;
      if (s_wren !== 1'b0) begin miscompares++; $display("FAIL mid_wren got %b want 0", s_wren); end
      if (done !== 1'b0)   begin miscompares++; $display("FAIL mid_done got %b want 0", done); end
      if (!zero)           begin miscompares++; $display("FAIL mid_data got nonzero want all 00"); end
      if (s_address !== 8'd0) begin miscompares++; $display("FAIL mid_saddr got %h want 00", s_address); end
      @(posedge clk); #1;
      vectors += 2;
      if (wr_count - w0 != 20) begin miscompares++; $display("FAIL mid_writes_after got %0d want 20", wr_count - w0); end
      if (s_wren !== 1'b0 || done !== 1'b0)
         begin miscompares++; $display("FAIL mid_idle got wren=%b done=%b want 0 0", s_wren, done); end
   endtask

   task automatic test_random();
      int cyc, r; bit to;
      logic [7:0] pt;
      for (int run = 0; run < 100; run++) begin
         do_reset();
         load_ksa();
         if (run % 2 == 0) begin
            for (int n = 0; n < 32; n++) rom[n] = 8'h00;
            ref_model();
            for (int n = 0; n < 32; n++) begin
               r = $urandom_range(0, 26);
               pt = (r == 26) ? 8'h20 : 8'(8'h61 + r);
               if (run % 4 == 2 && n == 31) pt = 8'h41;
               rom[n] = pt ^ exp_pt[n];
            end
         end else begin
            for (int n = 0; n < 32; n++) rom[n] = 8'($urandom);
         end
         ref_model();
         run_dut(cyc, to);
         vectors++;
         if (to) begin miscompares++; $display("FAIL rnd%0d_timeout got done=0 want done=1", run); end
         for (int n = 0; n < 32; n++) begin
            vectors++;
            if (decrypted_data[n] !== exp_pt[n])
               begin miscompares++; $display("FAIL rnd%0d_byte%0d got %h want %h", run, n, decrypted_data[n], exp_pt[n]); end
         end
         vectors++;
         if (text_valid !== exp_tv)
            begin miscompares++; $display("FAIL rnd%0d_tv got %b want %b", run, text_valid, exp_tv); end
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      for (int n = 0; n < 256; n++) smem[n] = 8'd0;
      for (int n = 0; n < 32; n++) rom[n] = 8'd0;
      test_reset();
      test_identity_zero();
      test_text_valid();
      test_timing_sticky();
      test_j_wrap();
      test_reset_midrun();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
